pdm_sequencer: RTL and testbench

PDM_SEQUENCER -- requirements
Module: pdm_sequencer

---
 rtl/pdm_sequencer.sv | 136 +++++++++++++
 tb/tb_pdm_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_sequencer.sv
// Plays a table of four-channel PDM set-points, one entry every P cycles, optionally looping.
// Define PDM_SEQ_CLAMP_EN to clamp every output channel to PDM_LIMIT.
module pdm_sequencer #(
  parameter int CFG_DATA_WIDTH  = 16,
  parameter int PDM_VALUE_WIDTH = 11,
  parameter int ADDR_WIDTH      = 4,
  parameter int PDM_LIMIT       = 1560
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [4*PDM_VALUE_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]        cfg_len,
  input  logic [31:0]                  cfg_period,
  input  logic                         cfg_loop,
  input  logic                         start,
  input  logic                         stop,
  output logic [CFG_DATA_WIDTH-1:0]    pdm_channel_1_nxt,
  output logic [CFG_DATA_WIDTH-1:0]    pdm_channel_2_nxt,
  output logic [CFG_DATA_WIDTH-1:0]    pdm_channel_3_nxt,
  output logic [CFG_DATA_WIDTH-1:0]    pdm_channel_4_nxt,
  output logic                         pdm_update,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        seq_index
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = PDM_VALUE_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] index;
  logic [ADDR_WIDTH-1:0] len;
  logic [31:0]           period;
  logic [31:0]           cnt;
  logic                  loop_en;
  logic                  prime;
  logic [4*PW-1:0]       mem [DEPTH];
  logic [4*PW-1:0]       entry;

  function automatic logic [CFG_DATA_WIDTH-1:0] shape(input logic [PW-1:0] v);
`ifdef PDM_SEQ_CLAMP_EN
    if (32'(v) > PDM_LIMIT) return CFG_DATA_WIDTH'(PDM_LIMIT);
    return CFG_DATA_WIDTH'(v);
`else
    return CFG_DATA_WIDTH'(v);
`endif
  endfunction

  // NOTE: the table is plain storage with no reset so it maps onto distributed RAM;
  // its contents survive areset by design.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Asynchronous read: a write on the same edge is seen only from the next cycle on.
  assign entry = mem[index];
  assign busy  = (state != IDLE);

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state             <= IDLE;
      index             <= '0;
      len               <= '0;
      period            <= 32'd2;
      loop_en           <= 1'b0;
      cnt               <= '0;
      prime             <= 1'b0;
      seq_index         <= '0;
      pdm_channel_1_nxt <= '0;
      pdm_channel_2_nxt <= '0;
      pdm_channel_3_nxt <= '0;
      pdm_channel_4_nxt <= '0;
      pdm_update        <= 1'b0;
      done              <= 1'b0;
    end else begin
      pdm_update <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len     <= cfg_len;
              period  <= (cfg_period < 32'd2) ? 32'd2 : cfg_period;
              loop_en <= cfg_loop;
              index   <= '0;
              done    <= 1'b0;
              prime   <= 1'b1;
              state   <= LOAD;
            end
          end
          LOAD: begin
            // The first step after start spends one extra cycle here.
            if (prime) begin
              prime <= 1'b0;
            end else begin
              pdm_channel_1_nxt <= shape(entry[PW-1:0]);
              pdm_channel_2_nxt <= shape(entry[2*PW-1:PW]);
              pdm_channel_3_nxt <= shape(entry[3*PW-1:2*PW]);
              pdm_channel_4_nxt <= shape(entry[4*PW-1:3*PW]);
              pdm_update        <= 1'b1;
              seq_index         <= index;
              cnt               <= '0;
              state             <= HOLD;
            end
          end
          HOLD: begin
            cnt <= cnt + 32'd1;
            // Continuing leaves HOLD one cycle early so the following LOAD lands on P.
            if (index != len) begin
              if (cnt == period - 32'd2) begin
                index <= index + 1'b1;
                state <= LOAD;
              end
            end else if (loop_en) begin
              if (cnt == period - 32'd2) begin
                index <= '0;
                state <= LOAD;
              end
            end else if (cnt == period - 32'd1) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdm_sequencer.sv
// Scoreboard bench for pdm_sequencer: expected updates are queued at launch and
// checked when pdm_update fires. Honors PDM_SEQ_CLAMP_EN the same way as the RTL.
module tb_pdm_sequencer;

  localparam int AW = 4;
  localparam int PW = 11;
  localparam int DW = 16;

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [4*PW-1:0] wr_data = '0;
  logic [AW-1:0]   cfg_len = '0;
  logic [31:0]     cfg_period = '0;
  logic            cfg_loop = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [DW-1:0]   ch1, ch2, ch3, ch4;
  logic            pdm_update, busy, done;
  logic [AW-1:0]   seq_index;

  pdm_sequencer dut (
    .aclk(aclk), .areset(areset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_len(cfg_len), .cfg_period(cfg_period), .cfg_loop(cfg_loop),
    .start(start), .stop(stop),
    .pdm_channel_1_nxt(ch1), .pdm_channel_2_nxt(ch2),
    .pdm_channel_3_nxt(ch3), .pdm_channel_4_nxt(ch4),
    .pdm_update(pdm_update), .busy(busy), .done(done), .seq_index(seq_index)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [4*DW-1:0] ch;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t          sb[$];
  logic [PW-1:0] model [16][4];
  int            tests = 0;
  int            fails = 0;

  function automatic logic [DW-1:0] exp_ch(input logic [PW-1:0] v);
`ifdef PDM_SEQ_CLAMP_EN
    return (v > 11'd1560) ? 16'd1560 : 16'(v);
`else
    return 16'(v);
`endif
  endfunction

  function automatic void push(input int c, input int a);
    exp_t e;
    e.cyc = c;
    e.ch  = {exp_ch(model[a][3]), exp_ch(model[a][2]), exp_ch(model[a][1]), exp_ch(model[a][0])};
    e.idx = AW'(a);
    sb.push_back(e);
  endfunction

  // Monitor: every pdm_update pulse must match the head of the scoreboard.
  always @(negedge aclk) begin
    if (!areset && pdm_update) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_update cyc=%0d ch=%0d/%0d/%0d/%0d idx=%0d", cyc, ch1, ch2, ch3, ch4, seq_index);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || {ch4, ch3, ch2, ch1} !== e.ch || seq_index !== e.idx || busy !== 1'b1) begin
          fails++;
          $display("FAIL update cyc=%0d ch=%h idx=%0d busy=%b, expected cyc=%0d ch=%h idx=%0d busy=1",
                   cyc, {ch4, ch3, ch2, ch1}, seq_index, busy, e.cyc, e.ch, e.idx);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge aclk);
  endtask

  task automatic write_entry(input int a, input int v1, input int v2, input int v3, input int v4);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = {PW'(v4), PW'(v3), PW'(v2), PW'(v1)};
    model[a][0] = PW'(v1);
    model[a][1] = PW'(v2);
    model[a][2] = PW'(v3);
    model[a][3] = PW'(v4);
    @(negedge aclk);
    wr_en = 1'b0;
  endtask

  // Start pulse; cfg_* is scrambled afterwards, which must have no effect.
  task automatic launch(input int len, input int per, input bit lp, output int c0);
    cfg_len    = AW'(len);
    cfg_period = per;
    cfg_loop   = lp;
    start      = 1'b1;
    c0         = cyc;
    @(negedge aclk);
    start      = 1'b0;
    cfg_len    = 4'd9;
    cfg_period = 32'd0;
    cfg_loop   = ~lp;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    write_entry(5, 11, 22, 33, 44);
    tests++;
    if ({ch1, ch2, ch3, ch4, pdm_update, busy, done, seq_index} !== '0) begin
      fails++;
      $display("FAIL reset_state ch=%0d/%0d/%0d/%0d upd=%b busy=%b done=%b idx=%0d, expected all 0",
               ch1, ch2, ch3, ch4, pdm_update, busy, done, seq_index);
    end
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_single_shot();
    int c0;
    for (int k = 0; k < 3; k++) write_entry(k, 100 * (k + 1), 10 + k, 7 * k, 2047 - k);
    launch(2, 5, 1'b0, c0);
    push(c0 + 3, 0); push(c0 + 8, 1); push(c0 + 13, 2);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL single_after_start busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    wait_cyc(c0 + 17);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL single_not_early busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    wait_cyc(c0 + 18);
    tests++;
    if (busy !== 1'b0 || done !== 1'b1 || ch1 !== 16'd300 || seq_index !== 4'd2) begin
      fails++;
      $display("FAIL single_done busy=%b done=%b ch1=%0d idx=%0d, expected busy=0 done=1 ch1=300 idx=2",
               busy, done, ch1, seq_index);
    end
  endtask

  task automatic test_loop_stop();
    int c0;
    launch(2, 5, 1'b1, c0);
    push(c0 + 3, 0); push(c0 + 8, 1); push(c0 + 13, 2); push(c0 + 18, 0);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL loop_done_cleared done=%b, expected 0", done);
    end
    wait_cyc(c0 + 20);
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || ch1 !== 16'd100 || seq_index !== 4'd0) begin
      fails++;
      $display("FAIL loop_stop busy=%b done=%b ch1=%0d idx=%0d, expected busy=0 done=0 ch1=100 idx=0",
               busy, done, ch1, seq_index);
    end
    wait_cyc(c0 + 32);
    tests++;
    if (ch1 !== 16'd100 || busy !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL loop_held ch1=%0d busy=%b pending=%0d, expected ch1=100 busy=0 pending=0", ch1, busy, sb.size());
    end
  endtask

  task automatic test_short_period();
    int c0;
    for (int per = 0; per < 2; per++) begin
      launch(1, per, 1'b0, c0);
      push(c0 + 3, 0); push(c0 + 5, 1);
      wait_cyc(c0 + 6);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL short_p%0d_busy busy=%b done=%b, expected busy=1 done=0", per, busy, done);
      end
      wait_cyc(c0 + 7);
      tests++;
      if (busy !== 1'b0 || done !== 1'b1 || ch1 !== 16'd200) begin
        fails++;
        $display("FAIL short_p%0d_done busy=%b done=%b ch1=%0d, expected busy=0 done=1 ch1=200", per, busy, done, ch1);
      end
    end
    cfg_len = 4'd2; cfg_period = 32'd5;
    start = 1'b1; stop = 1'b1;
    @(negedge aclk);
    start = 1'b0; stop = 1'b0;
    repeat (6) @(negedge aclk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      fails++; $display("FAIL start_stop busy=%b done=%b, expected busy=0 done=1", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int c0, c1;
    launch(2, 5, 1'b0, c0);
    push(c0 + 3, 0);
    wait_cyc(c0 + 5);
    areset = 1'b1;
    start  = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    start  = 1'b0;
    tests++;
    if ({ch1, ch2, ch3, ch4, pdm_update, busy, done, seq_index} !== '0 || sb.size() != 0) begin
      fails++;
      $display("FAIL reset_mid ch=%0d/%0d/%0d/%0d busy=%b done=%b idx=%0d pending=%0d, expected all 0",
               ch1, ch2, ch3, ch4, busy, done, seq_index, sb.size());
    end
    launch(2, 5, 1'b0, c1);
    push(c1 + 3, 0); push(c1 + 8, 1); push(c1 + 13, 2);
    wait_cyc(c1 + 18);
    tests++;
    if (done !== 1'b1 || ch1 !== 16'd300 || ch4 !== 16'd2045) begin
      fails++; $display("FAIL reset_restart done=%b ch1=%0d ch4=%0d, expected done=1 ch1=300 ch4=2045", done, ch1, ch4);
    end
  endtask

  task automatic test_clamp_single();
    int c0;
    logic [DW-1:0] want3;
`ifdef PDM_SEQ_CLAMP_EN
    want3 = 16'd1560;
`else
    want3 = 16'd2047;
`endif
    write_entry(0, 1561, 5, 2047, 1560);
    launch(0, 3, 1'b1, c0);
    push(c0 + 3, 0); push(c0 + 6, 0); push(c0 + 9, 0);
    wait_cyc(c0 + 10);
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    wait_cyc(c0 + 16);
    tests++;
    if (ch3 !== want3 || busy !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL clamp_ch3 ch3=%0d busy=%b pending=%0d, expected ch3=%0d busy=0 pending=0", ch3, busy, sb.size(), want3);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    for (int k = 0; k < 3; k++) write_entry(k, 100 * (k + 1), 10 + k, 7 * k, 2047 - k);
    launch(2, 4, 1'b0, c0);
    push(c0 + 3, 0);
    wait_cyc(c0 + 3);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    write_entry(1, 555, 1, 2, 3);
    push(c0 + 7, 1); push(c0 + 11, 2);
    wait_cyc(c0 + 14);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL b2b_not_early busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    wait_cyc(c0 + 15);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || ch1 !== 16'd300) begin
      fails++; $display("FAIL b2b_done done=%b busy=%b ch1=%0d, expected done=1 busy=0 ch1=300", done, busy, ch1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge aclk);
    test_reset();
    test_single_shot();
    test_loop_stop();
    test_short_period();
    test_reset_mid();
    test_clamp_single();
    test_back_to_back();
    repeat (4) @(negedge aclk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain pending=%0d, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
